// File: rtl/sram_responder.sv
// sram_responder: stand-in for the board SRAM on the far side of SRAM_DQ.
// It answers word reads after a configurable number of stable-address cycles.
// It commits writes on the rising edge of SRAM_WE_N, but only when the strobe
// was held long enough.
// Optional feature macro: SRAM_RESP_CHECK_EN. When defined, err/err_code
// report the first protocol violation (sticky until rst). When undefined,
// both outputs are tied to zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | read data on SRAM_DQ valid for cur_addr (or nothing fetched yet)
// RD_ACT   | address settling, counting read latency in rcnt
// WR_ACT   | write strobe low, capturing data for wa, counting in wcnt
// WR_ABORT | address moved during a write; waiting for strobe release
module sram_responder #(
  parameter int DEPTH_LOG2 = 8,
  parameter int READ_LAT   = 2,
  parameter int WRITE_MIN  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] SRAM_ADDR,
  input  logic        SRAM_WE_N,
  inout  wire  [63:0] SRAM_DQ,
  output logic        rd_valid,
  output logic [15:0] wr_count,
  output logic        err,
  output logic [1:0]  err_code
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_ACT   = 2'd1,
    WR_ACT   = 2'd2,
    WR_ABORT = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [16:0] cur_addr, cur_addr_d;
  logic        addr_known, addr_known_d;
  logic [2:0]  rcnt, rcnt_d;
  logic [2:0]  wcnt, wcnt_d;
  logic [16:0] wa, wa_d;
  logic [63:0] wd, wd_d;
  logic [63:0] rd_q;
  logic        rd_valid_d;
  logic [15:0] wr_count_d;
  logic        rd_load;
  logic        mem_we;
  logic        bus_drive;

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

`ifdef SRAM_RESP_CHECK_EN
  logic [1:0]  viol;
`endif

  // The strobe term is combinational so the bus is released in the same
  // cycle the controller starts driving write data.
  assign bus_drive = SRAM_WE_N && (state != WR_ACT) && (state != WR_ABORT);
  assign SRAM_DQ   = bus_drive ? rd_q : 64'bz;

  // Next-state and datapath decisions for all control registers.
  always_comb begin
    state_d      = state;
    cur_addr_d   = cur_addr;
    addr_known_d = addr_known;
    rcnt_d       = rcnt;
    wcnt_d       = wcnt;
    wa_d         = wa;
    wd_d         = wd;
    rd_valid_d   = rd_valid;
    wr_count_d   = wr_count;
    rd_load      = 1'b0;
    mem_we       = 1'b0;
`ifdef SRAM_RESP_CHECK_EN
    viol         = 2'd0;
`endif
    case (state)
      IDLE, RD_ACT: begin
        if (!SRAM_WE_N) begin
          // Write start also abandons any read in flight.
          state_d    = WR_ACT;
          wa_d       = SRAM_ADDR;
          wd_d       = SRAM_DQ;
          wcnt_d     = 3'd1;
          rd_valid_d = 1'b0;
        end else if (state == IDLE) begin
          if (!addr_known || (SRAM_ADDR != cur_addr)) begin
            state_d      = RD_ACT;
            cur_addr_d   = SRAM_ADDR;
            addr_known_d = 1'b1;
            rcnt_d       = 3'd1;
            rd_valid_d   = 1'b0;
          end
        end else if (SRAM_ADDR != cur_addr) begin
          cur_addr_d = SRAM_ADDR;
          rcnt_d     = 3'd1;
        end else if (rcnt == 3'(READ_LAT)) begin
          rd_load    = 1'b1;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          rcnt_d = rcnt + 3'd1;
        end
      end
      WR_ACT: begin
        if (!SRAM_WE_N) begin
          if (SRAM_ADDR == wa) begin
            wd_d = SRAM_DQ;
            if (wcnt != 3'd7) begin
              wcnt_d = wcnt + 3'd1;
            end
          end else begin
            state_d = WR_ABORT;
`ifdef SRAM_RESP_CHECK_EN
            viol    = 2'd2;
`endif
          end
        end else begin
          if (wcnt >= 3'(WRITE_MIN)) begin
            mem_we     = 1'b1;
            wr_count_d = wr_count + 16'd1;
          end else begin
`ifdef SRAM_RESP_CHECK_EN
            viol = 2'd1;
`endif
          end
          // Always refetch after a write so a read-back sees committed data.
          state_d      = RD_ACT;
          cur_addr_d   = SRAM_ADDR;
          addr_known_d = 1'b1;
          rcnt_d       = 3'd1;
        end
      end
      WR_ABORT: begin
        if (SRAM_WE_N) begin
          state_d      = RD_ACT;
          cur_addr_d   = SRAM_ADDR;
          addr_known_d = 1'b1;
          rcnt_d       = 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and read-data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cur_addr   <= 17'd0;
      addr_known <= 1'b0;
      rcnt       <= 3'd0;
      wcnt       <= 3'd0;
      wa         <= 17'd0;
      wd         <= 64'd0;
      rd_q       <= 64'd0;
      rd_valid   <= 1'b0;
      wr_count   <= 16'd0;
    end else begin
      state      <= state_d;
      cur_addr   <= cur_addr_d;
      addr_known <= addr_known_d;
      rcnt       <= rcnt_d;
      wcnt       <= wcnt_d;
      wa         <= wa_d;
      wd         <= wd_d;
      rd_valid   <= rd_valid_d;
      wr_count   <= wr_count_d;
      if (rd_load) begin
        rd_q <= mem[cur_addr[DEPTH_LOG2-1:0]];
      end
    end
  end

  // Word array: deliberately not reset, like the real part.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wa[DEPTH_LOG2-1:0]] <= wd;
    end
  end

`ifdef SRAM_RESP_CHECK_EN
  // Sticky error: only the first violation's cause is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err      <= 1'b0;
      err_code <= 2'd0;
    end else if (!err && (viol != 2'd0)) begin
      err      <= 1'b1;
      err_code <= viol;
    end
  end
`else
  assign err      = 1'b0;
  assign err_code = 2'd0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// tb_sram_responder: directed plus random bus traffic against a behavioural
// model of the SRAM (word array, write run lengths, stable-address runs).
module tb_sram_responder;

  localparam int DL = 8;
  localparam int RL = 3;
  localparam int WM = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] addr = 17'd0;
  logic        we_n = 1'b1;
  logic [63:0] tb_data = 64'd0;
  wire  [63:0] dq;
  logic        rd_valid;
  logic [15:0] wr_count;
  logic        err;
  logic [1:0]  err_code;

  int n_assert = 0;
  int n_fail   = 0;

  assign dq = we_n ? 64'bz : tb_data;

  always #5 clk = ~clk;

  sram_responder #(
    .DEPTH_LOG2(DL),
    .READ_LAT  (RL),
    .WRITE_MIN (WM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .SRAM_ADDR(addr),
    .SRAM_WE_N(we_n),
    .SRAM_DQ  (dq),
    .rd_valid (rd_valid),
    .wr_count (wr_count),
    .err      (err),
    .err_code (err_code)
  );

  // Reference model state
  logic [63:0] m_mem   [1 << DL];
  bit          m_known [1 << DL];
  int          run;
  bit          prev_high;
  logic [16:0] prev_addr;
  bit          in_wr, aborted;
  int          wlen;
  logic [16:0] waddr;
  logic [63:0] wdata;
  int          m_wrc;
  bit          m_err;
  int          m_code;
  logic [63:0] m_dq;
  bit          m_dq_known;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    run = 0; prev_high = 0; prev_addr = 17'd0;
    in_wr = 0; aborted = 0; wlen = 0;
    m_wrc = 0; m_err = 0; m_code = 0;
    m_dq = 64'd0; m_dq_known = 1;
  endtask

  task automatic flag_err(input int c);
    if (!m_err) begin
      m_err = 1;
      m_code = c;
    end
  endtask

  // One rising edge seen from the outside: write runs, then read runs.
  task automatic model_edge();
    if (!we_n) begin
      run = 0;
      if (!in_wr) begin
        in_wr = 1; aborted = 0; waddr = addr; wlen = 1; wdata = tb_data;
      end else if (!aborted) begin
        if (addr != waddr) begin
          aborted = 1;
          flag_err(2);
        end else begin
          wlen++;
          wdata = tb_data;
        end
      end
    end else begin
      if (in_wr) begin
        if (!aborted) begin
          if (wlen >= WM) begin
            m_mem[waddr[DL-1:0]] = wdata;
            m_known[waddr[DL-1:0]] = 1;
            m_wrc++;
          end else begin
            flag_err(1);
          end
        end
        in_wr = 0;
      end
      if (prev_high && addr == prev_addr && run > 0) run++;
      else run = 1;
      if (run == RL + 1) begin
        m_dq = m_mem[addr[DL-1:0]];
        m_dq_known = m_known[addr[DL-1:0]];
      end
    end
    prev_high = we_n;
    prev_addr = addr;
  endtask

  task automatic check_outputs();
    check("rd_valid", 64'(rd_valid), 64'(run >= RL + 1));
    check("wr_count", 64'(wr_count), 64'(m_wrc[15:0]));
`ifdef SRAM_RESP_CHECK_EN
    check("err", 64'(err), 64'(m_err));
    check("err_code", 64'(err_code), 64'(m_code[1:0]));
`else
    check("err", 64'(err), 64'd0);
    check("err_code", 64'(err_code), 64'd0);
`endif
    if (!we_n) check("bus_hiz", dq, tb_data);
    else if (m_dq_known) check("rd_data", dq, m_dq);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic [16:0] a, input logic w, input logic [63:0] d);
    addr = a; we_n = w; tb_data = d;
    #1;
    if (!w) check("bus_release", dq, d);
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [16:0] a);
    rst = 1; addr = a; we_n = 1; tb_data = 64'd0;
    model_reset();
    #1;
    check("rst_rd_valid", 64'(rd_valid), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);
    check("rst_dq", dq, 64'd0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic hold(input logic [16:0] a, input int n);
    for (int i = 0; i < n; i++) step(a, 1'b1, 64'd0);
  endtask

  logic [16:0] ra;
  int          op, len, n;
  bit          do_abort;

  initial begin
    for (int i = 0; i < (1 << DL); i++) begin
      m_known[i] = 0;
      m_mem[i] = 64'd0;
    end
    model_reset();
    @(negedge clk);

    // Read after reset
    do_reset(17'd5);
    hold(17'd5, RL + 2);

    // Basic write and read-back
    for (int i = 0; i < 4; i++) step(17'd3, 1'b0, 64'h00000000_DEADBEEF);
    hold(17'd3, RL + 2);

    // Known contents at 9 and 10, data changing on every low cycle
    step(17'd9, 1'b0, {$urandom, $urandom});
    step(17'd9, 1'b0, {$urandom, $urandom});
    step(17'd9, 1'b0, {$urandom, $urandom});
    step(17'd10, 1'b1, 64'd0);
    step(17'd10, 1'b0, {$urandom, $urandom});
    step(17'd10, 1'b0, {$urandom, $urandom});
    hold(17'd10, RL + 2);

    // Short write: discarded, first error cause is 1
    step(17'd7, 1'b0, 64'h55);
    hold(17'd7, RL + 2);

    // Address moves mid-write: abort, error cause stays 1
    step(17'd9, 1'b0, 64'h1111);
    step(17'd10, 1'b0, 64'h2222);
    step(17'd10, 1'b0, 64'h3333);
    step(17'd10, 1'b0, 64'h4444);
    hold(17'd10, RL + 2);
    hold(17'd9, RL + 2);

    // Address changing every cycle, then held
    for (int i = 0; i < 5; i++) step(17'(20 + i), 1'b1, 64'd0);
    hold(17'd3, RL + 2);

    // Aliased write: upper address bits ignored by the array
    step(17'h10103, 1'b0, 64'hA5A5_0000_1234_5678);
    step(17'h10103, 1'b0, 64'hA5A5_0000_1234_5678);
    hold(17'd3, RL + 2);
    step(17'd3, 1'b0, 64'h00000000_DEADBEEF);
    step(17'd3, 1'b0, 64'h00000000_DEADBEEF);
    hold(17'd3, RL + 2);

    // Reset in the middle of a write: no commit
    step(17'd3, 1'b0, 64'hFFFF_0000_FFFF_0000);
    step(17'd3, 1'b0, 64'hFFFF_0000_FFFF_0000);
    do_reset(17'd3);
    hold(17'd3, RL + 2);

    // Random traffic
    for (int t = 0; t < 200; t++) begin
      op = $urandom_range(0, 3);
      ra = 17'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) ra[16:DL] = (17 - DL)'($urandom);
      case (op)
        0, 1: begin
          n = $urandom_range(1, RL + 2);
          hold(ra, n);
        end
        2: begin
          len = $urandom_range(1, 4);
          do_abort = ($urandom_range(0, 4) == 0);
          for (int i = 0; i < len; i++) begin
            if (do_abort && i == 1) step(ra ^ 17'd1, 1'b0, {$urandom, $urandom});
            else step(ra, 1'b0, {$urandom, $urandom});
          end
          step(ra, 1'b1, 64'd0);
        end
        default: begin
          for (int i = 0; i < 3; i++) step(17'($urandom_range(0, 15)), 1'b1, 64'd0);
        end
      endcase
    end
    hold(17'd3, RL + 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
